// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared sizing for the CORDIC result buffer
package cordic_pkg;

  // Default result word width (x and y each)
  localparam int DW = 16;

  // Default number of buffer entries; must be a power of two, >= 2
  localparam int DEPTH = 4;

  // Pointer width for a buffer of the given depth
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PTR_W = ptr_w(DEPTH);

endpackage

// File: rtl/cordic_result_buffer_if.sv
// rtl/cordic_result_buffer_if.sv - pipeline-in / consumer-out handshake bundle
interface cordic_result_buffer_if #(
  parameter int DW = cordic_pkg::DW
) ();

  logic          in_valid;
  logic [DW-1:0] in_x;
  logic [DW-1:0] in_y;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_x;
  logic [DW-1:0] out_y;

  // Buffer side: takes pipeline results, presents the head entry
  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output out_valid, out_x, out_y
  );

  // Environment side: drives pipeline results and consumer ready
  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  out_valid, out_x, out_y
  );

endinterface

// File: rtl/cordic_buf_mem.sv
// rtl/cordic_buf_mem.sv - DEPTH x 2*DW register array, sync write, async read
module cordic_buf_mem #(
  parameter int DW    = cordic_pkg::DW,
  parameter int DEPTH = cordic_pkg::DEPTH,
  parameter int AW    = cordic_pkg::PTR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [2*DW-1:0] rdata
);

  logic [2*DW-1:0] rows [DEPTH];

  // Rows clear on reset so the head reads as zero while held in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rows[i] <= '0;
      end
    end else if (we) begin
      rows[waddr] <= wdata;
    end
  end

  // Read port is purely combinational so the head falls through
  assign rdata = rows[raddr];

endmodule

// File: rtl/cordic_result_buffer.sv
// rtl/cordic_result_buffer.sv - FWFT buffer absorbing an unstallable CORDIC pipeline
module cordic_result_buffer
  import cordic_pkg::*;
#(
  parameter  int DW    = cordic_pkg::DW,
  parameter  int DEPTH = cordic_pkg::DEPTH,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  cordic_result_buffer_if.slave  bus,
  output logic [CW-1:0]          count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            drop;
  logic [2*DW-1:0] head;

  // A full buffer still accepts a result when the head leaves in the same cycle
  always_comb begin
    pop  = bus.out_valid & bus.out_ready;
    push = bus.in_valid & ((count < FULL) | pop);
    drop = bus.in_valid & ~push;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy moves only when exactly one of push/pop happens
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  // Sticky drop flag; a drop in the clear cycle takes priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  cordic_buf_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({bus.in_x, bus.in_y}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.out_valid = (count != '0);
  assign bus.out_x     = head[2*DW-1:DW];
  assign bus.out_y     = head[DW-1:0];

endmodule

// File: tb/tb_cordic_result_buffer.sv
// tb/tb_cordic_result_buffer.sv - directed self-checking bench for cordic_result_buffer
module tb_cordic_result_buffer;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int checks;
  int errors;

  cordic_result_buffer_if #(.DW(16)) bus ();

  cordic_result_buffer #(
    .DW    (16),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    clr_ovf       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_x",     32'(bus.out_x), 32'd0);
    check("rst_y",     32'(bus.out_y), 32'd0);
    step();
    reset = 1'b1;

    // single push into empty buffer, no bypass in the push cycle
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h1234;
    bus.in_y     = 16'hABCD;
    #1;
    check("nobypass_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("one_valid", 32'(bus.out_valid), 32'd1);
    check("one_x",     32'(bus.out_x), 32'h1234);
    check("one_y",     32'(bus.out_y), 32'hABCD);
    check("one_count", 32'(count), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("one_pop_count", 32'(count), 32'd0);

    // ready while empty does nothing
    step();
    bus.out_ready = 1'b0;
    check("empty_ready_count", 32'(count), 32'd0);
    check("empty_ready_valid", 32'(bus.out_valid), 32'd0);
    check("empty_ready_ovf",   32'(overflow), 32'd0);

    // five pushes, fifth dropped
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 16'(i);
      bus.in_y     = 16'(i + 100);
      step();
      check("fill_count", 32'(count), (i < 4) ? 32'(i) : 32'd4);
      check("fill_ovf",   32'(overflow), (i < 5) ? 32'd0 : 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check("drain_x", 32'(bus.out_x), 32'(k));
      check("drain_y", 32'(bus.out_y), 32'(k + 100));
      step();
    end
    bus.out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_ovf",   32'(overflow), 32'd1);

    // refill, then drop concurrent with clear: drop wins
    for (int i = 20; i <= 23; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 16'(i);
      bus.in_y     = 16'(i);
      step();
    end
    bus.in_x = 16'd99;
    clr_ovf  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("clr_drop_ovf",   32'(overflow), 32'd1);
    check("clr_drop_count", 32'(count), 32'd4);
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // full with simultaneous push and pop
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_x      = 16'd9;
    bus.in_y      = 16'd9;
    #1;
    check("fullpp_head", 32'(bus.out_x), 32'd20);
    step();
    bus.in_valid = 1'b0;
    check("fullpp_count", 32'(count), 32'd4);
    check("fullpp_ovf",   32'(overflow), 32'd0);
    check("fullpp_x0", 32'(bus.out_x), 32'd21);
    step();
    check("fullpp_x1", 32'(bus.out_x), 32'd22);
    step();
    check("fullpp_x2", 32'(bus.out_x), 32'd23);
    step();
    check("fullpp_x3", 32'(bus.out_x), 32'd9);
    step();
    check("fullpp_empty", 32'(count), 32'd0);

    // streaming through wrap-around
    for (int i = 0; i <= 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 16'(i);
      bus.in_y     = 16'(i + 16'h0100);
      step();
      check("stream_count", 32'(count), 32'd1);
      check("stream_x",     32'(bus.out_x), 32'(i));
      check("stream_y",     32'(bus.out_y), 32'(i + 16'h0100));
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    check("stream_end_count", 32'(count), 32'd0);
    check("stream_end_ovf",   32'(overflow), 32'd0);

    // asynchronous reset with three held entries
    for (int i = 40; i <= 42; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 16'(i);
      bus.in_y     = 16'(i);
      step();
    end
    bus.in_valid = 1'b0;
    check("pre_reset_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_x",     32'(bus.out_x), 32'd0);
    #1;
    reset = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.in_x     = 16'd77;
    bus.in_y     = 16'd78;
    step();
    bus.in_valid = 1'b0;
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_x",     32'(bus.out_x), 32'd77);
    check("post_rst_y",     32'(bus.out_y), 32'd78);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
